// File: rtl/fir_coeff_streamer.sv
// rtl/fir_coeff_streamer.sv - coefficient bank that streams one FIR pass per start request.
// Define FIR_COEFF_SHADOW_BANK_EN for a shadow bank with load_commit; default build has none.
module fir_coeff_streamer #(
    parameter int NUM_TAPS    = 32,
    parameter int COEFF_WIDTH = 32,
    parameter int ADDR_WIDTH  = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load_wr_en,
    input  logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic [COEFF_WIDTH-1:0] load_data,
`ifdef FIR_COEFF_SHADOW_BANK_EN
    input  logic                   load_commit,
`endif
    output logic                   load_busy,
    input  logic                   start,
    output logic                   tap_valid,
    input  logic                   tap_ready,
    output logic [COEFF_WIDTH-1:0] tap_data,
    output logic [ADDR_WIDTH-1:0]  tap_index,
    output logic                   tap_last,
    output logic                   pass_done
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TAPS - 1);

    state_t                   state;
    logic [COEFF_WIDTH-1:0]   bank [NUM_TAPS];
    logic [31:0]              addr_ext;
    logic                     addr_ok;
    logic                     xfer;
    logic [ADDR_WIDTH-1:0]    next_index;

    assign addr_ext   = 32'(load_addr);
    assign addr_ok    = addr_ext < 32'(NUM_TAPS);
    assign xfer       = tap_valid & tap_ready;
    assign next_index = tap_index + ADDR_WIDTH'(1);

    // The active bank is frozen outside IDLE, so a direct read stays stable across stalls.
    assign tap_data = tap_valid ? bank[tap_index] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tap_valid <= 1'b0;
            tap_index <= '0;
            tap_last  <= 1'b0;
            pass_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pass_done <= 1'b0;
                    if (start) begin
                        state     <= STREAM;
                        tap_valid <= 1'b1;
                        tap_index <= '0;
                        tap_last  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (tap_last) begin
                            state     <= DONE;
                            tap_valid <= 1'b0;
                            tap_last  <= 1'b0;
                            tap_index <= '0;
                            pass_done <= 1'b1;
                        end else begin
                            tap_index <= next_index;
                            tap_last  <= (next_index == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    pass_done <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    tap_valid <= 1'b0;
                    tap_last  <= 1'b0;
                    pass_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIR_COEFF_SHADOW_BANK_EN
    logic [COEFF_WIDTH-1:0] shadow [NUM_TAPS];
    logic                   commit_pend;
    logic                   wr_ok;
    logic                   do_copy;

    assign load_busy = 1'b0;
    assign wr_ok     = load_wr_en & addr_ok;
    assign do_copy   = (state == IDLE) & (load_commit | commit_pend);

    always_ff @(posedge clock) begin
        if (!reset && wr_ok) begin
            shadow[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            commit_pend <= 1'b0;
        end else if (load_commit) begin
            commit_pend <= 1'b1;
        end
    end

    // A write in the commit cycle is forwarded so the copy sees it.
    always_ff @(posedge clock) begin
        if (!reset && do_copy) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                bank[i] <= (wr_ok && addr_ext == 32'(i)) ? load_data : shadow[i];
            end
        end
    end
`else
    assign load_busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset && load_wr_en && !load_busy && addr_ok) begin
            bank[load_addr] <= load_data;
        end
    end
`endif

endmodule

// File: tb/tb_fir_coeff_streamer.sv
// tb/tb_fir_coeff_streamer.sv - randomized self-checking bench for fir_coeff_streamer.
module tb_fir_coeff_streamer;
    localparam int NT = 32;
    localparam int CW = 32;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_wr_en;
    logic [AW-1:0] load_addr;
    logic [CW-1:0] load_data;
    logic          load_busy;
    logic          start;
    logic          tap_valid;
    logic          tap_ready;
    logic [CW-1:0] tap_data;
    logic [AW-1:0] tap_index;
    logic          tap_last;
    logic          pass_done;
`ifdef FIR_COEFF_SHADOW_BANK_EN
    logic          load_commit;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [CW-1:0] ref_bank [NT];
    logic [CW-1:0] lp_half [16] = '{
        32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000A,
        32'h00000012, 32'h00000008, 32'hFFFFFFE4, 32'hFFFFFFC2,
        32'hFFFFFFD9, 32'h00000030, 32'h000000A5, 32'h00000110,
        32'h00000175, 32'h000001C9, 32'h00000210, 32'h00000243};

    fir_coeff_streamer #(.NUM_TAPS(NT), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_wr_en (load_wr_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
`ifdef FIR_COEFF_SHADOW_BANK_EN
        .load_commit(load_commit),
`endif
        .load_busy  (load_busy),
        .start      (start),
        .tap_valid  (tap_valid),
        .tap_ready  (tap_ready),
        .tap_data   (tap_data),
        .tap_index  (tap_index),
        .tap_last   (tap_last),
        .pass_done  (pass_done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_all(input bit lowpass);
        for (int i = 0; i < NT; i++) begin
            ref_bank[i] = lowpass ? lp_half[(i < 16) ? i : NT - 1 - i] : $urandom;
            load_wr_en  = 1'b1;
            load_addr   = AW'(i);
            load_data   = ref_bank[i];
            step();
        end
        load_wr_en = 1'b0;
`ifdef FIR_COEFF_SHADOW_BANK_EN
        load_commit = 1'b1;
        step();
        load_commit = 1'b0;
`endif
    endtask

    task automatic begin_pass();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called in the first cycle after start; returns in the cycle after the final transfer.
    task automatic stream_pass(input int stall_pct, input bit poke_start);
        int            exp_idx = 0;
        int            cyc = 0;
        bit            done = 0;
        bit            have_prev = 0;
        logic [CW-1:0] pd;
        logic [AW-1:0] pi;
        logic          pl;
        while (!done && cyc < 2000) begin
            cyc++;
            n_cmp++;
            if (tap_valid !== 1'b1) begin
                n_bad++; $display("FAIL stream_valid idx %0d: got %b expected 1", exp_idx, tap_valid);
            end
            n_cmp++;
            if (tap_index !== AW'(exp_idx)) begin
                n_bad++; $display("FAIL stream_index: got %0d expected %0d", tap_index, exp_idx);
            end
            n_cmp++;
            if (tap_data !== ref_bank[exp_idx]) begin
                n_bad++; $display("FAIL stream_data idx %0d: got %h expected %h", exp_idx, tap_data, ref_bank[exp_idx]);
            end
            n_cmp++;
            if (tap_last !== (exp_idx == NT - 1)) begin
                n_bad++; $display("FAIL stream_last idx %0d: got %b expected %b", exp_idx, tap_last, exp_idx == NT - 1);
            end
            n_cmp++;
            if (pass_done !== 1'b0) begin
                n_bad++; $display("FAIL stream_pass_done idx %0d: got %b expected 0", exp_idx, pass_done);
            end
            if (have_prev) begin
                n_cmp++;
                if ({tap_data, tap_index, tap_last} !== {pd, pi, pl}) begin
                    n_bad++; $display("FAIL stall_hold: got %h/%0d/%b expected %h/%0d/%b", tap_data, tap_index, tap_last, pd, pi, pl);
                end
            end
            pd        = tap_data;
            pi        = tap_index;
            pl        = tap_last;
            tap_ready = ($urandom_range(0, 99) >= stall_pct);
            start     = poke_start && (cyc == 3);
            if (tap_ready) begin
                have_prev = 0;
                if (exp_idx == NT - 1) done = 1;
                else exp_idx++;
            end else begin
                have_prev = 1;
            end
            step();
        end
        start = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++; $display("FAIL stream_timeout: got %0d taps expected %0d", exp_idx, NT);
        end
        n_cmp++;
        if ({tap_valid, pass_done} !== 2'b01) begin
            n_bad++; $display("FAIL done_cycle valid/pass_done: got %b%b expected 01", tap_valid, pass_done);
        end
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if ({tap_valid, pass_done, tap_last} !== 3'b000) begin
            n_bad++; $display("FAIL %s valid/done/last: got %b%b%b expected 000", tag, tap_valid, pass_done, tap_last);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        step(); step(); step();
        n_cmp++;
        if ({tap_valid, tap_last, pass_done, load_busy} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_flags: got %b%b%b%b expected 0000", tap_valid, tap_last, pass_done, load_busy);
        end
        n_cmp++;
        if (tap_index !== '0) begin
            n_bad++; $display("FAIL reset_index: got %0d expected 0", tap_index);
        end
        n_cmp++;
        if (tap_data !== '0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", tap_data);
        end
        reset = 1'b0; start = 1'b0;
        step();
        check_idle("start_during_reset");
    endtask

    task automatic test_full_pass();
        load_all(1'b1);
        begin_pass();
        stream_pass(0, 1'b0);
        step();
        check_idle("after_full_pass");
    endtask

    task automatic test_random_stall();
        load_all(1'b0);
        for (int r = 0; r < 3; r++) begin
            begin_pass();
            stream_pass(50, 1'b0);
            step();
        end
    endtask

`ifndef FIR_COEFF_SHADOW_BANK_EN
    task automatic test_busy_write();
        begin_pass();
        tap_ready = 1'b0;
        n_cmp++;
        if (load_busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_in_stream: got %b expected 1", load_busy);
        end
        load_wr_en = 1'b1; load_addr = AW'(3); load_data = 32'h12345678;
        step();
        load_wr_en = 1'b0;
        stream_pass(30, 1'b0);
        n_cmp++;
        if (load_busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_in_done: got %b expected 1", load_busy);
        end
        step();
        n_cmp++;
        if (load_busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_in_idle: got %b expected 0", load_busy);
        end
        begin_pass();
        stream_pass(0, 1'b0);
        step();
    endtask
`endif

    task automatic test_write_with_start();
        logic [CW-1:0] v;
        v = $urandom;
        ref_bank[0] = v;
        load_wr_en = 1'b1; load_addr = '0; load_data = v; start = 1'b1;
`ifdef FIR_COEFF_SHADOW_BANK_EN
        load_commit = 1'b1;
`endif
        step();
        load_wr_en = 1'b0; start = 1'b0;
`ifdef FIR_COEFF_SHADOW_BANK_EN
        load_commit = 1'b0;
`endif
        stream_pass(25, 1'b0);
        step();
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        begin_pass();
        tap_ready = 1'b1;
        while (tap_index !== AW'(10) && guard < 50) begin
            step();
            guard++;
        end
        n_cmp++;
        if (tap_index !== AW'(10)) begin
            n_bad++; $display("FAIL reach_index10: got %0d expected 10", tap_index);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("mid_reset");
        n_cmp++;
        if ({tap_index, tap_data} !== '0) begin
            n_bad++; $display("FAIL mid_reset_outputs: got %0d/%h expected 0/0", tap_index, tap_data);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("after_mid_reset");
        end
        begin_pass();
        stream_pass(0, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        begin_pass();
        stream_pass(0, 1'b0);
        start = 1'b1;
        step();
        check_idle("start_in_done_ignored");
        step();
        start = 1'b0;
        stream_pass(20, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_idle("no_queued_pass");
        end
    endtask

`ifdef FIR_COEFF_SHADOW_BANK_EN
    task automatic test_shadow();
        begin_pass();
        tap_ready = 1'b0;
        load_wr_en = 1'b1; load_addr = '0; load_data = 32'h00000001;
        step();
        load_wr_en = 1'b0; load_commit = 1'b1;
        n_cmp++;
        if (load_busy !== 1'b0) begin
            n_bad++; $display("FAIL shadow_busy: got %b expected 0", load_busy);
        end
        step();
        load_commit = 1'b0;
        stream_pass(0, 1'b0);
        step();
        ref_bank[0] = 32'h00000001;
        begin_pass();
        stream_pass(0, 1'b0);
        step();
    endtask
`endif

    initial begin
        reset = 1'b1; load_wr_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; tap_ready = 1'b0;
`ifdef FIR_COEFF_SHADOW_BANK_EN
        load_commit = 1'b0;
`endif
        test_reset();
        test_full_pass();
        test_random_stall();
`ifndef FIR_COEFF_SHADOW_BANK_EN
        test_busy_write();
`endif
        test_write_with_start();
        test_mid_reset();
        test_back_to_back();
`ifdef FIR_COEFF_SHADOW_BANK_EN
        test_shadow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
